// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and constants for the data-memory responder.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DW_BYTES    = 8;
    localparam int OFF_W       = 3;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    // Out-of-range latency settings saturate rather than wrap the wait counter.
    function automatic int clamp_latency(input int lat);
        if (lat < 0)
            return 0;
        else if (lat > LATENCY_MAX)
            return LATENCY_MAX;
        else
            return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Request/response bundle between CPU load/store port and memory.
// Revision : 1.0
// ============================================================================
interface dmem_responder_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : Single-port synchronous RAM, read-before-write on a shared edge.
// Revision : 1.0
// ============================================================================
module dmem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              en,
    input  wire logic              we,
    input  wire logic [IDX_W-1:0]  index,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                r_mem[index] <= wdata;
            r_rdata <= r_mem[index];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Doubleword load/store responder with programmable wait states.
// Revision : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_responder_if.slave bus
);

    localparam int                c_IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  c_LAT   = CNT_W'(clamp_latency(LATENCY));
    localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic                r_err;
    logic [c_IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic                r_load_ok;

    logic                w_req_ready;
    logic                w_accept;
    logic                w_req_err;
    logic                w_commit;
    logic                w_arr_en;
    logic [ADDR_W-1:0]   w_word;
    logic [DATA_W-1:0]   w_arr_rdata;

    assign w_req_ready = (r_state == IDLE) && !reset;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_word      = bus.req_addr >> OFF_W;
    assign w_req_err   = (bus.req_addr[OFF_W-1:0] != '0) || (w_word >= c_DEPTH);
    assign w_commit    = (r_state == WAIT) && (r_cnt == '0);
    // Reset wins over a commit landing on the same edge.
    assign w_arr_en    = w_commit && !r_err && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_load_ok   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write <= bus.req_write;
                        r_idx   <= bus.req_addr[c_IDX_W+OFF_W-1:OFF_W];
                        r_wdata <= bus.req_wdata;
                        r_err   <= w_req_err;
                        r_cnt   <= c_LAT;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_err;
                        r_load_ok   <= !r_write && !r_err;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_load_ok   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (w_arr_en),
        .we    (r_write),
        .index (r_idx),
        .wdata (r_wdata),
        .rdata (w_arr_rdata)
    );

    // Array read register only moves on a commit, so the masked value holds through RESP.
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_load_ok ? w_arr_rdata : '0;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the CPU's load/store port, which is the memory side of the CPU's MemRead/MemWrite accesses. It accepts one doubleword read or write request per transaction over a valid/ready handshake. It inserts a configurable number of wait states, then returns read data or a write acknowledge with an error flag. Later multi-cycle CPU revisions use it in place of the zero-latency memory model, and it stays the single owner of the data array.

Parameters:
DATA_W, 64, data bus width in bits; fixed at 64 (doubleword).
ADDR_W, 64, byte address width.
DEPTH, 256, number of 64-bit words in the array.
LATENCY, 2, wait states between accept and response; legal range 0..15.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data.
rsp_valid  out  1  response present.
rsp_ready  in  1  requester accepts the response.
rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
rsp_err  out  1  access was misaligned or out of range.
busy  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- Clock is clk. Reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, wait counter 0. Array contents are not reset.
- req_ready = (state==IDLE) && !reset, driven combinationally. There is no request pipelining: at most one transaction is outstanding.
- Accept: on an edge where req_valid && req_ready:
  - latch write, addr and wdata;
  - word index = addr[log2(DEPTH)+2:3];
  - err = (addr[2:0] != 0) || (addr >> 3 >= DEPTH).
- FSM IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: on accept, load cnt = LATENCY and go to WAIT.
  - WAIT: while cnt != 0, decrement cnt. When cnt == 0, perform the access on that edge and go to RESP.
  - RESP: hold rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready; on that edge clear rsp_valid and go to IDLE.
- Latency: rsp_valid first rises exactly LATENCY+1 cycles after the accept edge. With LATENCY = 0 it rises 1 cycle after accept.
- Access at the WAIT->RESP edge:
  - store without error: array[index] <= wdata; rsp_rdata <= 0.
  - load without error: rsp_rdata <= array[index], the value before any write on that same edge.
  - err = 1: no array access; rsp_rdata <= 0; rsp_err <= 1.
- Backpressure: if rsp_ready is held low, the responder stays in RESP indefinitely and req_ready stays 0.
- New request in RESP: req_valid is ignored until the cycle after the response handshake. Back-to-back throughput is therefore one transaction per LATENCY+3 cycles minimum.
- Input stability: req_addr, req_wdata and req_write changing after accept have no effect.
- Reset mid-transaction: abort immediately and return to IDLE. A store whose commit edge coincides with reset is NOT written, because reset has priority over the commit.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - DW_BYTES = 8 and the offset width constant 3;
  - LATENCY_MAX = 15.
- Sub-module dmem_array: single-port synchronous RAM. Ports: clk, en, we, index, wdata, rdata. Read-before-write on the same edge. The FSM stays in dmem_responder.

Test Plan:
- Store then load, LATENCY = 2: store addr 0x10, data 0xDEADBEEF_CAFEF00D; then load addr 0x10 -> rsp_valid 3 cycles after each accept, load rsp_rdata = 0xDEADBEEF_CAFEF00D, rsp_err = 0.
- Misaligned access: load addr 0x13 -> rsp_err = 1, rsp_rdata = 0. Store addr 0x0B data 0x1 -> rsp_err = 1, and a later load of 0x08 still returns its previous value.
- Out of range, DEPTH = 256: store addr 0x800 -> rsp_err = 1, with no wrap onto word 0 (load 0x0 unchanged).
- Backpressure: hold rsp_ready = 0 for 5 cycles while pulsing req_valid -> rsp_valid stays 1, rsp_rdata stays stable, req_ready stays 0, and the second request is accepted only after the handshake.
- Reset mid-store: assert reset on the WAIT->RESP edge of a store of 0x55 to addr 0x20 -> FSM returns to IDLE, no response is produced, and a later load of 0x20 returns the old data.
- LATENCY = 0 sweep: 100 random aligned loads and stores against a scoreboard model -> data matches, each response arrives exactly 1 cycle after accept.
